// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: load-use bubble,
// MEM-stage redirect squash, data-memory freeze, saturating counters and a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] wait_cycles,
  output logic             mem_timeout
);

  localparam int unsigned WT_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic {RUN, WAIT} state_e;

  state_e           state_q, state_d;
  logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [WT_W-1:0]  wait_base;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] waitc_q, waitc_d;

  logic freeze, lu, redirect_act, lu_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    freeze       = dmem_req & ~dmem_ready;
    lu           = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    redirect_act = ~freeze & mem_redirect;
    lu_act       = ~freeze & ~mem_redirect & lu;
  end

  // Outputs are forced to the normal pattern while reset is held.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        mem_wb_flush  = 1'b1;
      end else if (redirect_act) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (lu_act) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // A freeze seen in RUN starts a new consecutive run; in WAIT it extends the current one.
  always_comb begin
    state_d    = freeze ? WAIT : RUN;
    wait_base  = (state_q == WAIT) ? wait_cnt_q : '0;
    wait_cnt_d = '0;
    if (freeze) begin
      wait_cnt_d = (wait_base == WT_W'(WAIT_TIMEOUT)) ? wait_base : wait_base + WT_W'(1);
    end
    timeout_d = timeout_q | (freeze & (wait_cnt_d == WT_W'(WAIT_TIMEOUT)));
    stall_d   = sat_inc(stall_q, lu_act);
    flush_d   = sat_inc(flush_q, redirect_act);
    waitc_d   = sat_inc(waitc_q, freeze);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
      waitc_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      waitc_q    <= waitc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  assign wait_cycles  = waitc_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=2, WAIT_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 2;

  // Control vector order: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes}
  localparam logic [8:0] NORM = 9'b11111_0000;
  localparam logic [8:0] FRZ  = 9'b00000_0001;
  localparam logic [8:0] RED  = 9'b11111_1110;
  localparam logic [8:0] LU   = 9'b00111_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic          mem_redirect, dmem_req, dmem_ready;
  logic          pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CW-1:0] stall_cycles, flush_events, wait_cycles;
  logic          mem_timeout;
  logic [8:0]    ctl;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_redirect(mem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .wait_cycles(wait_cycles),
    .mem_timeout(mem_timeout)
  );

  assign ctl = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu_rs1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    // Reset with a freeze pending: outputs must still show the normal pattern.
    idle();
    rst_n = 1'b0; dmem_req = 1'b1;
    #1 check("rst_ctl", 32'(ctl), 32'(NORM));
    tick();
    check("rst_stall", 32'(stall_cycles), 0);
    check("rst_flush", 32'(flush_events), 0);
    check("rst_wait", 32'(wait_cycles), 0);
    check("rst_tmo", 32'(mem_timeout), 0);
    rst_n = 1'b1; idle();
    #1 check("idle_ctl", 32'(ctl), 32'(NORM));

    // Load-use on rs1: one bubble, then the load is in MEM and ID proceeds.
    tick();
    set_lu_rs1();
    #1 check("lu_rs1_ctl", 32'(ctl), 32'(LU));
    tick();
    check("lu_rs1_cnt", 32'(stall_cycles), 1);
    idle();
    #1 check("lu_after_ctl", 32'(ctl), 32'(NORM));

    // x0 destination and an unused matching operand never stall.
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1 check("x0_ctl", 32'(ctl), 32'(NORM));
    tick();
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    #1 check("unused_ctl", 32'(ctl), 32'(NORM));
    tick();
    check("no_stall_cnt", 32'(stall_cycles), 1);
    id_uses_rs2 = 1'b1;
    #1 check("lu_rs2_ctl", 32'(ctl), 32'(LU));
    tick();
    check("lu_rs2_cnt", 32'(stall_cycles), 2);
    idle();

    // Single-cycle redirect.
    mem_redirect = 1'b1;
    #1 check("redir_ctl", 32'(ctl), 32'(RED));
    tick();
    check("redir_cnt", 32'(flush_events), 1);
    idle();

    // Three not-ready cycles, then ready.
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("frz_ctl", 32'(ctl), 32'(FRZ));
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("release_ctl", 32'(ctl), 32'(NORM));
    tick();
    check("wait_cnt", 32'(wait_cycles), 3);
    check("no_tmo", 32'(mem_timeout), 0);
    idle();
    #1 check("run_ctl", 32'(ctl), 32'(NORM));
    tick();

    // Freeze dominates redirect and load-use; on release the redirect wins.
    dmem_req = 1'b1; mem_redirect = 1'b1; set_lu_rs1();
    for (int i = 0; i < 2; i++) begin
      #1 check("all_frz_ctl", 32'(ctl), 32'(FRZ));
      tick();
    end
    check("all_frz_flush", 32'(flush_events), 1);
    dmem_ready = 1'b1;
    #1 check("all_rel_ctl", 32'(ctl), 32'(RED));
    tick();
    check("all_rel_flush", 32'(flush_events), 2);
    check("all_rel_stall", 32'(stall_cycles), 2);
    check("wait_sat", 32'(wait_cycles), 3);
    idle();

    // Timeout after the 4th consecutive not-ready cycle; sticky after ready.
    do_reset();
    dmem_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("tmo_%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
    end
    dmem_ready = 1'b1;
    tick();
    idle();
    tick();
    check("tmo_sticky", 32'(mem_timeout), 1);
    #1 check("tmo_run_ctl", 32'(ctl), 32'(NORM));

    // Stall counter saturates at 3.
    do_reset();
    set_lu_rs1();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat_%0d", i), 32'(stall_cycles), (i >= 3) ? 3 : i);
    end

    // Reset in the middle of a wait clears everything.
    idle();
    dmem_req = 1'b1; mem_redirect = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1 check("rst_wait_ctl", 32'(ctl), 32'(NORM));
    tick();
    check("fin_stall", 32'(stall_cycles), 0);
    check("fin_flush", 32'(flush_events), 0);
    check("fin_wait", 32'(wait_cycles), 0);
    check("fin_tmo", 32'(mem_timeout), 0);
    rst_n = 1'b1; idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
